// File: rtl/gcm_pkg.sv
// Shared definitions for the GHASH sequencer: state encoding, block width and
// helpers for byte masking and building the len(A)||len(C) block.
package gcm_pkg;

   localparam int GCM_BLK_W = 128;

   // Reduction constant for the bit-reflected GCM field representation
   localparam logic [GCM_BLK_W-1:0] GCM_R = {8'he1, 120'h0};

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_START    = 3'd1,
      ST_MUL      = 3'd2,
      ST_CAPTURE  = 3'd3,
      ST_LEN      = 3'd4,
      ST_FINISHED = 3'd5
   } ghash_state_t;

   function automatic logic [4:0] norm_bytes(input logic [4:0] n);
      return (n == 5'd0 || n > 5'd16) ? 5'd16 : n;
   endfunction

   function automatic logic [7:0] blk_bits(input logic [4:0] n);
      return {norm_bytes(n), 3'b000};
   endfunction

   // Byte 0 lives in bits [127:120]; bytes at index >= n are zeroed
   function automatic logic [GCM_BLK_W-1:0] mask_bytes(input logic [GCM_BLK_W-1:0] data,
                                                       input logic [4:0] n);
      logic [4:0]           nb;
      logic [GCM_BLK_W-1:0] m;
      nb = norm_bytes(n);
      m  = data;
      for (int i = 0; i < 16; i++) begin
         if (5'(i) >= nb) m[GCM_BLK_W-1-8*i -: 8] = 8'h00;
      end
      return m;
   endfunction

   function automatic logic [GCM_BLK_W-1:0] len_block(input logic [63:0] len_a,
                                                      input logic [63:0] len_c);
      return {len_a, len_c};
   endfunction

endpackage

// File: rtl/galois_mul.sv
// Bit-serial GF(2^128) multiplier in GCM bit order. While rst is high the
// operands are loaded; z is final once valid rises.
module galois_mul
   import gcm_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [GCM_BLK_W-1:0] x,
   input  logic [GCM_BLK_W-1:0] y,
   output logic [GCM_BLK_W-1:0] z,
   output logic                 valid
);

   logic [GCM_BLK_W-1:0] x_sh, v_q, z_q;
   logic [7:0]           cnt;

   function automatic logic [GCM_BLK_W-1:0] v_shift(input logic [GCM_BLK_W-1:0] v);
      return v[0] ? ((v >> 1) ^ GCM_R) : (v >> 1);
   endfunction

   // The load edge already consumes bit 0 of X, so 127 further steps finish
   // the product and the controller sees a 130-cycle block occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         z_q  <= x[GCM_BLK_W-1] ? y : '0;
         v_q  <= v_shift(y);
         x_sh <= x << 1;
         cnt  <= 8'd1;
      end else if (cnt != 8'd128) begin
         z_q  <= x_sh[GCM_BLK_W-1] ? (z_q ^ v_q) : z_q;
         v_q  <= v_shift(v_q);
         x_sh <= x_sh << 1;
         cnt  <= cnt + 8'd1;
      end
   end

   assign z     = z_q;
   assign valid = (cnt == 8'd128);

endmodule

// File: rtl/ghash_ctrl.sv
// GHASH sequencer: accepts AAD/CT blocks, runs Y <= (Y ^ blk) * H on the
// bit-serial multiplier and optionally appends the len(A)||len(C) block.
//
// state    | meaning
// IDLE     | waiting for a block (blk_ready=1)
// START    | multiplier load cycle (X=Xop, Y=H)
// MUL      | multiplier running, wait for valid
// CAPTURE  | Y <= product, choose next pass
// LEN      | build Xop from the length block
// FINISHED | done=1, ghash_out holds the tag input until init
module ghash_ctrl
   import gcm_pkg::*;
#(
   parameter int CNT_W    = 39,
   parameter bit AUTO_LEN = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [GCM_BLK_W-1:0] h_in,
   input  logic                 h_load,
   input  logic                 init,
   input  logic [GCM_BLK_W-1:0] blk_data,
   input  logic [4:0]           blk_bytes,
   input  logic                 blk_is_ct,
   input  logic                 blk_last,
   input  logic                 blk_valid,
   output logic                 blk_ready,
   output logic [GCM_BLK_W-1:0] ghash_out,
   output logic                 done,
   output logic                 busy,
   output logic                 err
);

   ghash_state_t state, state_nx;

   logic [GCM_BLK_W-1:0] y_q, h_q, xop_q, z, y_b;
   logic [CNT_W-1:0]     len_a, len_c, len_a_b, len_c_b;
   logic                 ct_seen, ct_seen_b, last_q, last_len;
   logic                 mult_valid, mult_rst;
   logic                 idle_like, do_init, do_hload, xfer, drop;

   assign idle_like = (state == ST_IDLE) || (state == ST_FINISHED);
   assign do_init   = init & idle_like;
   assign do_hload  = h_load & idle_like;
   assign xfer      = blk_valid & blk_ready & (state == ST_IDLE);

   // A block accepted together with init sees the freshly cleared message state
   assign y_b       = do_init ? '0 : y_q;
   assign len_a_b   = do_init ? '0 : len_a;
   assign len_c_b   = do_init ? '0 : len_c;
   assign ct_seen_b = do_init ? 1'b0 : ct_seen;
   assign drop      = xfer & ~blk_is_ct & ct_seen_b;

   assign mult_rst  = rst | (state == ST_START);

   galois_mul u_mul (
      .clk   (clk),
      .rst   (mult_rst),
      .x     (xop_q),
      .y     (h_q),
      .z     (z),
      .valid (mult_valid)
   );

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (xfer) begin
               if (!drop)         state_nx = ST_START;
               else if (blk_last) state_nx = AUTO_LEN ? ST_LEN : ST_FINISHED;
            end
         end
         ST_START:   state_nx = ST_MUL;
         ST_MUL:     if (mult_valid) state_nx = ST_CAPTURE;
         ST_CAPTURE: begin
            if (last_len)    state_nx = ST_FINISHED;
            else if (last_q) state_nx = AUTO_LEN ? ST_LEN : ST_FINISHED;
            else             state_nx = ST_IDLE;
         end
         ST_LEN:      state_nx = ST_START;
         ST_FINISHED: if (do_init) state_nx = ST_IDLE;
         default:     state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         blk_ready <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nx;
         blk_ready <= (state_nx == ST_IDLE);
         done      <= (state_nx == ST_FINISHED);
         busy      <= !((state_nx == ST_IDLE) || (state_nx == ST_FINISHED));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         y_q      <= '0;
         h_q      <= '0;
         xop_q    <= '0;
         len_a    <= '0;
         len_c    <= '0;
         ct_seen  <= 1'b0;
         last_q   <= 1'b0;
         last_len <= 1'b0;
         err      <= 1'b0;
      end else begin
         if (do_hload) h_q <= h_in;
         if (do_init) begin
            y_q      <= '0;
            len_a    <= '0;
            len_c    <= '0;
            ct_seen  <= 1'b0;
            last_q   <= 1'b0;
            last_len <= 1'b0;
            err      <= 1'b0;
         end
         case (state)
            ST_IDLE: begin
               if (xfer) begin
                  if (drop) begin
                     err <= 1'b1;
                  end else begin
                     xop_q  <= y_b ^ mask_bytes(blk_data, blk_bytes);
                     last_q <= blk_last;
                     if (blk_is_ct) begin
                        len_c   <= len_c_b + CNT_W'(blk_bits(blk_bytes));
                        ct_seen <= 1'b1;
                     end else begin
                        len_a <= len_a_b + CNT_W'(blk_bits(blk_bytes));
                     end
                  end
               end
            end
            ST_LEN: begin
               xop_q    <= y_q ^ len_block(64'(len_a), 64'(len_c));
               last_len <= 1'b1;
            end
            ST_CAPTURE: y_q <= z;
            default: ;
         endcase
      end
   end

   assign ghash_out = y_q;

endmodule

// File: tb/tb_ghash_ctrl.sv
// Directed bench for ghash_ctrl: GCM test case 2 with and without the
// automatic length block, partial blocks, ordering errors, timing and reset.
module tb_ghash_ctrl;

   localparam logic [127:0] H_TC2  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
   localparam logic [127:0] C_TC2  = 128'h0388dace60b6a392f328c2b971b2fe78;
   localparam logic [127:0] X1_TC2 = 128'h5e2ec746917062882c85b0685353deb7;
   localparam logic [127:0] G_TC2  = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
   localparam logic [127:0] R_POLY = {8'he1, 120'h0};
   localparam int           LIMIT  = 2000;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [127:0] h_in = '0;
   logic         h_load = 1'b0, init = 1'b0;
   logic [127:0] blk_data = '0;
   logic [4:0]   blk_bytes = 5'd16;
   logic         blk_is_ct = 1'b0, blk_last = 1'b0;
   logic         blk_valid = 1'b0, blk_valid0 = 1'b0;
   logic         blk_ready, blk_ready0;
   logic [127:0] ghash_out, ghash_out0;
   logic         done, done0, busy, busy0, err, err0;

   int n_cmp = 0;
   int n_err = 0;

   ghash_ctrl #(.CNT_W(39), .AUTO_LEN(1'b1)) dut (
      .clk(clk), .rst(rst), .h_in(h_in), .h_load(h_load), .init(init),
      .blk_data(blk_data), .blk_bytes(blk_bytes), .blk_is_ct(blk_is_ct),
      .blk_last(blk_last), .blk_valid(blk_valid), .blk_ready(blk_ready),
      .ghash_out(ghash_out), .done(done), .busy(busy), .err(err)
   );

   ghash_ctrl #(.CNT_W(39), .AUTO_LEN(1'b0)) dut0 (
      .clk(clk), .rst(rst), .h_in(h_in), .h_load(h_load), .init(init),
      .blk_data(blk_data), .blk_bytes(blk_bytes), .blk_is_ct(blk_is_ct),
      .blk_last(blk_last), .blk_valid(blk_valid0), .blk_ready(blk_ready0),
      .ghash_out(ghash_out0), .done(done0), .busy(busy0), .err(err0)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] gf_mul(input logic [127:0] a, input logic [127:0] b);
      logic [127:0] zz, vv;
      zz = '0;
      vv = b;
      for (int i = 0; i < 128; i++) begin
         if (a[127-i]) zz = zz ^ vv;
         vv = vv[0] ? ((vv >> 1) ^ R_POLY) : (vv >> 1);
      end
      return zz;
   endfunction

   task automatic pulse_init(input logic [127:0] h);
      @(negedge clk);
      h_in   = h;
      h_load = 1'b1;
      init   = 1'b1;
      @(negedge clk);
      h_load = 1'b0;
      init   = 1'b0;
   endtask

   task automatic send_blk(input bit sel, input logic [127:0] d, input logic [4:0] nb,
                           input bit ct, input bit last);
      int n;
      @(negedge clk);
      blk_data  = d;
      blk_bytes = nb;
      blk_is_ct = ct;
      blk_last  = last;
      if (sel) blk_valid0 = 1'b1;
      else     blk_valid  = 1'b1;
      n = 0;
      while (!(sel ? blk_ready0 : blk_ready) && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      if (n >= LIMIT) check_val("send_timeout", 128'(n), 128'(LIMIT - 1));
      @(negedge clk);
      blk_valid  = 1'b0;
      blk_valid0 = 1'b0;
      blk_last   = 1'b0;
   endtask

   task automatic wait_ready(input bit sel);
      int n;
      n = 0;
      while (!(sel ? blk_ready0 : blk_ready) && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      if (n >= LIMIT) check_val("ready_timeout", 128'(n), 128'(LIMIT - 1));
   endtask

   task automatic wait_done(input bit sel, input string tag);
      int n;
      n = 0;
      while (!(sel ? done0 : done) && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      check_val(tag, 128'(sel ? done0 : done), 128'd1);
   endtask

   initial begin
      logic [127:0] a1, c1, a2, exp;
      logic [127:0] blks [3];
      logic [127:0] y1, y2, y3;
      int           lowcnt, n;

      // Reset values
      repeat (3) @(negedge clk);
      check_val("rst_ghash", ghash_out, '0);
      check_val("rst_done",  128'(done), '0);
      check_val("rst_busy",  128'(busy), '0);
      check_val("rst_err",   128'(err), '0);
      check_val("rst_ready", 128'(blk_ready), '0);
      rst = 1'b0;
      @(negedge clk);
      check_val("idle_ready", 128'(blk_ready), 128'd1);

      // GCM test case 2 with automatic length block
      pulse_init(H_TC2);
      send_blk(1'b0, C_TC2, 5'd16, 1'b1, 1'b1);
      wait_done(1'b0, "tc2_done");
      check_val("tc2_ghash", ghash_out, G_TC2);
      check_val("tc2_err",   128'(err), '0);
      check_val("tc2_busy",  128'(busy), '0);

      // Same message with an explicit length block
      pulse_init(H_TC2);
      send_blk(1'b1, C_TC2, 5'd16, 1'b1, 1'b0);
      wait_ready(1'b1);
      check_val("tc2_x1", ghash_out0, X1_TC2);
      send_blk(1'b1, 128'h80, 5'd16, 1'b1, 1'b1);
      wait_done(1'b1, "explicit_done");
      check_val("explicit_ghash", ghash_out0, G_TC2);

      // Partial block: 4 valid bytes, lenC = 32
      pulse_init(H_TC2);
      send_blk(1'b0, C_TC2, 5'd4, 1'b1, 1'b1);
      wait_done(1'b0, "partial_done");
      exp = gf_mul(gf_mul(128'h0388dace_00000000_00000000_00000000, H_TC2) ^ 128'h20, H_TC2);
      check_val("partial_ghash", ghash_out, exp);

      // Ordering: AAD (bytes=0 means 16), CT, then late AAD dropped
      a1 = 128'hfeedfacedeadbeef_feedfacedeadbeef;
      c1 = 128'h0123456789abcdef_fedcba9876543210;
      a2 = 128'h5555aaaa5555aaaa_5555aaaa5555aaaa;
      pulse_init(H_TC2);
      send_blk(1'b0, a1, 5'd0, 1'b0, 1'b0);
      send_blk(1'b0, c1, 5'd16, 1'b1, 1'b0);
      wait_ready(1'b0);
      check_val("order_err_before", 128'(err), '0);
      send_blk(1'b0, a2, 5'd16, 1'b0, 1'b1);
      wait_done(1'b0, "order_done");
      check_val("order_err_after", 128'(err), 128'd1);
      exp = gf_mul(gf_mul(gf_mul(a1, H_TC2) ^ c1, H_TC2) ^ {64'd128, 64'd128}, H_TC2);
      check_val("order_ghash", ghash_out, exp);

      // Back-to-back blocks with valid held high; init/h_load while busy
      blks[0] = 128'h00112233445566778899aabbccddeeff;
      blks[1] = 128'hffeeddccbbaa99887766554433221100;
      blks[2] = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
      y1 = gf_mul(blks[0], H_TC2);
      y2 = gf_mul(y1 ^ blks[1], H_TC2);
      y3 = gf_mul(y2 ^ blks[2], H_TC2);
      pulse_init(H_TC2);
      n = 0;
      while (!blk_ready && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      for (int b = 0; b < 3; b++) begin
         blk_data  = blks[b];
         blk_bytes = 5'd16;
         blk_is_ct = (b != 0);
         blk_last  = (b == 2);
         blk_valid = 1'b1;
         @(negedge clk);
         if (b == 2) begin
            blk_valid = 1'b0;
            blk_last  = 1'b0;
         end else begin
            lowcnt = 0;
            while (!blk_ready && lowcnt < 300) begin
               lowcnt++;
               if (b == 1 && lowcnt == 50) begin
                  h_in = '1; init = 1'b1; h_load = 1'b1;
               end else if (b == 1 && lowcnt == 51) begin
                  h_in = H_TC2; init = 1'b0; h_load = 1'b0;
               end
               @(negedge clk);
            end
            check_val($sformatf("ready_low_%0d", b), 128'(lowcnt), 128'd130);
            check_val($sformatf("y_after_%0d", b), ghash_out, (b == 0) ? y1 : y2);
         end
      end
      wait_done(1'b0, "stream_done");
      check_val("stream_ghash", ghash_out, gf_mul(y3 ^ {64'd128, 64'd256}, H_TC2));

      // Reset in the middle of a multiply
      pulse_init(H_TC2);
      send_blk(1'b0, C_TC2, 5'd16, 1'b1, 1'b0);
      wait_ready(1'b0);
      send_blk(1'b0, C_TC2, 5'd16, 1'b1, 1'b1);
      repeat (61) @(negedge clk);
      check_val("mid_busy", 128'(busy), 128'd1);
      rst = 1'b1;
      @(negedge clk);
      check_val("mid_rst_ghash", ghash_out, '0);
      check_val("mid_rst_done",  128'(done), '0);
      check_val("mid_rst_busy",  128'(busy), '0);
      check_val("mid_rst_err",   128'(err), '0);
      check_val("mid_rst_ready", 128'(blk_ready), '0);
      rst = 1'b0;
      pulse_init(H_TC2);
      send_blk(1'b0, C_TC2, 5'd16, 1'b1, 1'b1);
      wait_done(1'b0, "rerun_done");
      check_val("rerun_ghash", ghash_out, G_TC2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
